// File: rtl/order_gen.sv
`default_nettype none
// =============================================================================
// order_gen : debounced key press -> pseudo-random order -> show-ahead FIFO
// Revision  : 1.0
// =============================================================================
module order_gen #(
   parameter int          DEBOUNCE_CYCLES = 32,
   parameter int          FIFO_DEPTH      = 4,
   parameter int          PRICE_W         = 4,
   parameter int          QTY_W           = 3,
   parameter int          ID_W            = 8,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic                          CLOCK_50,
   input  logic                          resetn,
   input  logic                          key_n,
   output logic                          order_valid,
   input  logic                          order_ready,
   output logic                          order_side,
   output logic [PRICE_W-1:0]            order_price,
   output logic [QTY_W-1:0]              order_qty,
   output logic [ID_W-1:0]               order_id,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [7:0]                    drop_count
);

   localparam int              c_AW       = $clog2(FIFO_DEPTH);
   localparam int              c_CW       = c_AW + 1;
   localparam int              c_DW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int              c_EW       = 1 + PRICE_W + QTY_W + ID_W;
   localparam logic [c_CW-1:0] c_FULL     = c_CW'(FIFO_DEPTH);
   localparam logic [c_DW-1:0] c_DB_LAST  = c_DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [15:0]     c_TAPS     = 16'hB400;

   logic                r_sync1;
   logic                r_key_s;
   logic                r_stable;
   logic                r_stable_d;
   logic [c_DW-1:0]     r_db_cnt;
   logic [15:0]         r_lfsr;
   logic [ID_W-1:0]     r_id;
   logic [c_EW-1:0]     r_mem [FIFO_DEPTH];
   logic [c_AW-1:0]     r_wr_ptr;
   logic [c_AW-1:0]     r_rd_ptr;
   logic [c_CW-1:0]     r_count;
   logic [7:0]          r_drops;

   logic                w_press;
   logic                w_pop;
   logic                w_full;
   logic                w_push;
   logic                w_drop;
   logic [QTY_W-1:0]    w_qty_raw;
   logic [QTY_W-1:0]    w_qty;
   logic [c_EW-1:0]     w_entry;

   // Key path: two-flop synchronizer, then a level is accepted only after it
   // has differed from the current stable level for DEBOUNCE_CYCLES samples.
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         r_sync1    <= 1'b1;
         r_key_s    <= 1'b1;
         r_stable   <= 1'b1;
         r_stable_d <= 1'b1;
         r_db_cnt   <= '0;
      end else begin
         r_sync1    <= key_n;
         r_key_s    <= r_sync1;
         r_stable_d <= r_stable;
         if (r_key_s == r_stable) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == c_DB_LAST) begin
            r_stable <= r_key_s;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + c_DW'(1);
         end
      end
   end

   assign w_press = r_stable_d & ~r_stable;

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         r_lfsr <= LFSR_SEED;
      end else begin
         r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? c_TAPS : 16'h0000);
      end
   end

   assign w_qty_raw = r_lfsr[PRICE_W+QTY_W:PRICE_W+1];
   assign w_qty     = (w_qty_raw == '0) ? QTY_W'(1) : w_qty_raw;
   assign w_entry   = {r_lfsr[0], r_lfsr[PRICE_W:1], w_qty, r_id};

   // Fullness is evaluated after a same-cycle pop so a press on a full FIFO
   // that is being drained still gets in.
   assign w_pop  = (r_count != '0) & order_ready;
   assign w_full = (r_count == c_FULL) & ~w_pop;
   assign w_push = w_press & ~w_full;
   assign w_drop = w_press & w_full;

   always_ff @(posedge CLOCK_50) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_entry;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_id     <= '0;
         r_drops  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_AW'(1);
            r_id     <= r_id + ID_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_AW'(1);
         end
         r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
         if (w_drop && (r_drops != 8'hFF)) begin
            r_drops <= r_drops + 8'd1;
         end
      end
   end

   assign order_valid = (r_count != '0);
   assign {order_side, order_price, order_qty, order_id} = r_mem[r_rd_ptr];
   assign fifo_count  = r_count;
   assign drop_count  = r_drops;

endmodule
`default_nettype wire

// File: tb/tb_order_gen.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// tb_order_gen : randomized bench with a behavioural order_gen model
// Revision     : 1.0
// =============================================================================
module tb_order_gen;

   localparam int          DC    = 32;
   localparam int          DEPTH = 4;
   localparam int          PW    = 4;
   localparam int          QW    = 3;
   localparam int          IW    = 8;
   localparam logic [15:0] SEED  = 16'hACE1;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          key_n = 1'b1;
   logic          order_ready = 1'b0;
   logic          order_valid;
   logic          order_side;
   logic [PW-1:0] order_price;
   logic [QW-1:0] order_qty;
   logic [IW-1:0] order_id;
   logic [2:0]    fifo_count;
   logic [7:0]    drop_count;

   always #5 clk = ~clk;

   order_gen #(
      .DEBOUNCE_CYCLES (DC),
      .FIFO_DEPTH      (DEPTH),
      .PRICE_W         (PW),
      .QTY_W           (QW),
      .ID_W            (IW),
      .LFSR_SEED       (SEED)
   ) dut (
      .CLOCK_50    (clk),
      .resetn      (resetn),
      .key_n       (key_n),
      .order_valid (order_valid),
      .order_ready (order_ready),
      .order_side  (order_side),
      .order_price (order_price),
      .order_qty   (order_qty),
      .order_id    (order_id),
      .fifo_count  (fifo_count),
      .drop_count  (drop_count)
   );

   typedef struct packed {
      logic          side;
      logic [PW-1:0] price;
      logic [QW-1:0] qty;
      logic [IW-1:0] id;
   } ord_t;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      n_tests++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   ord_t          mq[$];
   logic [15:0]   m_lfsr;
   logic          m_stable;
   int            m_run;
   logic          m_fell;
   logic [1:0]    m_sync;
   logic [IW-1:0] m_nid;
   int            m_drops;
   bit            m_init = 1'b0;
   ord_t          m_first;

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic ord_t make_order(input logic [15:0] l, input logic [IW-1:0] id);
      ord_t o;
      o.side  = l[0];
      o.price = l[PW:1];
      o.qty   = l[PW+QW:PW+1];
      if (o.qty == 0) o.qty = 1;
      o.id    = id;
      return o;
   endfunction

   always @(posedge clk) begin
      if (!resetn) begin
         mq.delete();
         m_lfsr   = SEED;
         m_stable = 1'b1;
         m_run    = 0;
         m_fell   = 1'b0;
         m_sync   = 2'b11;
         m_nid    = '0;
         m_drops  = 0;
         m_init   = 1'b1;
      end else if (m_init) begin
         logic ks;
         if (mq.size() != 0 && order_ready) void'(mq.pop_front());
         if (m_fell) begin
            if (mq.size() < DEPTH) begin
               mq.push_back(make_order(m_lfsr, m_nid));
               m_nid = m_nid + 1'b1;
            end else if (m_drops < 255) begin
               m_drops++;
            end
         end
         ks     = m_sync[1];
         m_fell = 1'b0;
         if (ks != m_stable) begin
            m_run++;
            if (m_run == DC) begin
               m_fell   = m_stable & ~ks;
               m_stable = ks;
               m_run    = 0;
            end
         end else begin
            m_run = 0;
         end
         m_sync = {m_sync[0], key_n};
         m_lfsr = lfsr_step(m_lfsr);
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("valid", {31'd0, order_valid}, {31'd0, (mq.size() != 0)});
         chk("count", {29'd0, fifo_count}, mq.size());
         chk("drops", {24'd0, drop_count}, m_drops);
         if (mq.size() != 0)
            chk("head", {16'd0, order_side, order_price, order_qty, order_id}, {16'd0, mq[0]});
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      for (int i = 0; i < 5; i++) begin
         key_n = i[0];
         @(negedge clk);
      end
      chk("rst_valid", {31'd0, order_valid}, 32'd0);
      chk("rst_count", {29'd0, fifo_count}, 32'd0);
      chk("rst_drops", {24'd0, drop_count}, 32'd0);
      key_n  = 1'b1;
      resetn = 1'b1;
   endtask

   task automatic press(input int low, input int high);
      key_n = 1'b0;
      cyc(low);
      key_n = 1'b1;
      cyc(high);
   endtask

   task automatic drain_check(input int first_id, input int n);
      order_ready = 1'b1;
      for (int k = 0; k < n; k++) begin
         chk("drain_valid", {31'd0, order_valid}, 32'd1);
         chk("drain_id", {24'd0, order_id}, first_id + k);
         @(negedge clk);
      end
      order_ready = 1'b0;
      chk("drain_empty", {31'd0, order_valid}, 32'd0);
   endtask

   initial begin
      int lat;
      bool_seen: begin end
      // reset with key toggling; nothing appears afterwards
      do_reset();
      cyc(60);
      chk("idle_valid", {31'd0, order_valid}, 32'd0);

      // single clean press with latency measurement
      do_reset();
      cyc(10);
      key_n = 1'b0;
      lat = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         lat = i;
         if (order_valid) break;
      end
      chk_range("latency", lat, 2 + DC, 2 + DC + 2);
      if (lat < 100) cyc(100 - lat);
      key_n = 1'b1;
      cyc(60);
      chk("single_count", {29'd0, fifo_count}, 32'd1);
      chk("single_id", {24'd0, order_id}, 32'd0);
      chk_range("single_qty", int'(order_qty), 1, 7);
      m_first = (mq.size() != 0) ? mq[0] : '0;

      // short glitch is rejected
      do_reset();
      cyc(10);
      press(20, 80);
      chk("glitch_count", {29'd0, fifo_count}, 32'd0);

      // bounce followed by solid press gives exactly one order
      do_reset();
      cyc(10);
      for (int i = 0; i < 4; i++) press(5, 5);
      press(100, 60);
      chk("bounce_count", {29'd0, fifo_count}, 32'd1);

      // overflow: 6 presses into a 4-deep FIFO
      do_reset();
      for (int i = 0; i < 6; i++) press(50, 50);
      chk("ovf_count", {29'd0, fifo_count}, 32'd4);
      chk("ovf_drops", {24'd0, drop_count}, 32'd2);
      drain_check(0, 4);

      // press on a full FIFO coincident with a pop
      do_reset();
      for (int i = 0; i < 4; i++) press(50, 50);
      chk("full_count", {29'd0, fifo_count}, 32'd4);
      key_n = 1'b0;
      lat = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         lat = i;
         if (m_fell) break;
      end
      chk("press_seen", {31'd0, m_fell}, 32'd1);
      order_ready = 1'b1;
      @(negedge clk);
      order_ready = 1'b0;
      chk("simul_count", {29'd0, fifo_count}, 32'd4);
      chk("simul_drops", {24'd0, drop_count}, 32'd0);
      cyc(20);
      key_n = 1'b1;
      cyc(60);
      drain_check(1, 4);

      // reset mid-operation reproduces the first post-reset order
      do_reset();
      for (int i = 0; i < 3; i++) press(50, 50);
      chk("mid_count", {29'd0, fifo_count}, 32'd3);
      do_reset();
      chk("mid_rst_count", {29'd0, fifo_count}, 32'd0);
      cyc(10);
      press(100, 60);
      chk("mid_id", {24'd0, order_id}, 32'd0);
      chk("mid_fields", {16'd0, order_side, order_price, order_qty, order_id}, {16'd0, m_first});

      // randomized presses, bounces and back-pressure
      do_reset();
      for (int it = 0; it < 40; it++) begin
         int lowlen;
         int highlen;
         lowlen  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 25)) : int'($urandom_range(40, 80));
         highlen = $urandom_range(40, 70);
         key_n = 1'b0;
         for (int c = 0; c < lowlen; c++) begin
            order_ready = ($urandom_range(0, 3) == 0);
            @(negedge clk);
         end
         key_n = 1'b1;
         for (int c = 0; c < highlen; c++) begin
            order_ready = ($urandom_range(0, 5) == 0);
            @(negedge clk);
         end
      end
      order_ready = 1'b0;
      cyc(5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/order_gen.md
Name: order_gen

Overview:
- Upstream stage of the order-matching engine: turns presses of the "new order" push-button into pseudo-random buy/sell orders.
- Debounces the raw active-low key and produces one press event per physical press.
- Each press samples a free-running LFSR to form side/price/qty, tags the order with a sequential ID and queues it in a small FIFO.
- The matching engine drains the FIFO through a valid/ready handshake.

Parameters:
- DEBOUNCE_CYCLES, 32, number of consecutive stable synced samples before a key level change is accepted (board build overrides to 500000).
- FIFO_DEPTH, 4, order queue entries; must be a power of two, at least 2.
- PRICE_W, 4, price field width.
- QTY_W, 3, quantity field width.
- ID_W, 8, order ID width.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- CLOCK_50  in  1  system clock (50 MHz).
- resetn  in  1  synchronous active-low reset.
- key_n  in  1  raw push-button, active-low, asynchronous to CLOCK_50 (wired to KEY[3]).
- order_valid  out  1  FIFO head holds a valid order.
- order_ready  in  1  matching engine accepts the head this cycle.
- order_side  out  1  0 = buy, 1 = sell.
- order_price  out  PRICE_W  limit price.
- order_qty  out  QTY_W  quantity, never 0.
- order_id  out  ID_W  sequential order tag.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- drop_count  out  8  orders lost because the FIFO was full; saturates at 255.

Behaviour:
- Reset: one clock, synchronous, active-low; resetn is sampled on the CLOCK_50 rising edge only.
- Reset state:
  - order_valid=0; fifo_count=0; drop_count=0.
  - Next order ID = 0.
  - LFSR = LFSR_SEED.
  - Synchronizer flops and debounced level = 1 (released).
  - Debounce counter = 0.
  - FIFO pointers = 0.
- Reset mid-operation: queued orders are discarded, the next press starts again at ID 0, and the same press sequence reproduces the same order fields.
- Synchronizer: key_n passes through two flops; the second flop is key_s.
- Debounce:
  - key_s == stable: counter clears.
  - key_s != stable: counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, stable <= key_s and the counter clears.
  - Any pulse shorter than DEBOUNCE_CYCLES cycles produces no level change.
- Press event: a single-cycle pulse on the cycle after stable goes 1->0. Release (0->1) generates nothing.
- LFSR:
  - 16-bit Galois, taps 16'hB400.
  - Advances every cycle regardless of presses; never reaches 0.
- Order formation, from LFSR value L on the press cycle:
  - side = L[0].
  - price = L[PRICE_W:1].
  - qty = L[PRICE_W+QTY_W:PRICE_W+1], with 0 replaced by 1.
  - id = next-ID counter.
- Push, press while FIFO not full: entry written, next ID increments (wraps mod 2^ID_W).
- Drop, press while FIFO full: entry not written, ID not consumed, drop_count += 1 (saturating at 255).
- Full is judged after the same-cycle pop: a press on a full FIFO coincident with order_valid&&order_ready is accepted and fifo_count stays unchanged.
- FIFO is show-ahead:
  - Outputs present the head entry whenever order_valid=1.
  - order_valid = (fifo_count != 0).
  - Pop on order_valid && order_ready.
  - order_ready while order_valid=0 is ignored.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Pointers wrap mod FIFO_DEPTH.
- Latency: press event on cycle N into an empty FIFO -> order_valid=1 on cycle N+1.
- Head stability: while order_valid=1 and order_ready=0, every order_* output stays stable.
- Output registers: fifo_count and drop_count are registered and update on the same edge as the push/pop.

Test Plan:
- Reset: hold resetn=0 for 5 cycles with key_n toggling -> order_valid=0, fifo_count=0, drop_count=0; no order appears after release.
- Single clean press: key_n low 100 cycles, order_ready=0 -> exactly one order with id=0, qty in 1..7; order_valid rises 2+DEBOUNCE_CYCLES+1 cycles after the low edge (+/-1); fields match a bit-accurate LFSR model seeded 16'hACE1.
- Glitch rejection:
  - key_n low for 20 cycles (< 32) -> no order, fifo_count=0.
  - Bounce pattern of 5-cycle pulses followed by 100 cycles low -> exactly one order.
- Overflow: 6 presses with order_ready=0 -> fifo_count=4, drop_count=2; then order_ready=1 -> ids 0,1,2,3 emitted in order, then order_valid=0.
- Simultaneous push/pop at full: FIFO full with order_ready pulsed on the press-event cycle -> id 4 accepted, fifo_count stays 4, drop_count unchanged.
- Reset mid-operation: 3 orders queued, then reset -> fifo_count=0; the next press yields id=0 with fields identical to the first post-reset order of the single-press test.
